data_memory: RTL and testbench

//  Word-addressed 16-bit data RAM for the 5-stage pipelined processor. It serves loads and stores from the MEM stage.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_perf_ctr.sv | 21 ++
 rtl/data_memory.sv | 74 +++++++
 tb/tb_data_memory.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data RAM: default geometry, reset fill value and word type.
package dmem_pkg;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] INIT0 = '0;

  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/dmem_perf_ctr.sv
// Saturating 16-bit event counter with asynchronous active-low clear; used for data-RAM activity stats.
module dmem_perf_ctr (
  input  logic        clk,
  input  logic        clrN,
  input  logic        inc,
  output logic [15:0] count
);

  function automatic logic [15:0] satInc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge clrN) begin
    if (!clrN) begin
      count <= 16'h0000;
    end else if (inc) begin
      count <= satInc(count);
    end
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data RAM for the MEM stage: combinational read, synchronous write, async clear.
// Optional activity counters (wr_count, rd_addr_changes) are built when DMEM_PERF_EN is defined.
module data_memory #(
  parameter int DW = dmem_pkg::DW,
  parameter int AW = dmem_pkg::AW,
  parameter logic [DW-1:0] INIT0 = DW'(dmem_pkg::INIT0)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   addr,
  input  logic [DW-1:0] write_data,
  input  logic          mem_write,
  output logic [DW-1:0] read_data
`ifdef DMEM_PERF_EN
  ,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_addr_changes
`endif
);
  import dmem_pkg::*;

  localparam int Depth = 1 << AW;

  logic [DW-1:0] mem [0:Depth-1];
  logic [AW-1:0] wordIdx;
  logic          unusedAddrBits;

  // Upper address bits alias onto the same words; nothing flags an out-of-range address.
  assign wordIdx        = addr[AW-1:0];
  assign unusedAddrBits = ^addr[15:AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= INIT0;
      end
    end else if (mem_write == 1'b1) begin
      mem[wordIdx] <= write_data;
    end
  end

  // No write bypass: a same-cycle read sees the old word; the core forwards around it.
  assign read_data = mem[wordIdx];

`ifdef DMEM_PERF_EN
  logic [15:0] prevAddr;
  logic        addrChanged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevAddr <= 16'h0000;
    end else begin
      prevAddr <= addr;
    end
  end

  assign addrChanged = (addr != prevAddr);

  dmem_perf_ctr uWrCtr (
    .clk  (clk),
    .clrN (reset),
    .inc  (mem_write == 1'b1),
    .count(wr_count)
  );

  dmem_perf_ctr uAddrCtr (
    .clk  (clk),
    .clrN (reset),
    .inc  (addrChanged),
    .count(rd_addr_changes)
  );
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory; define DMEM_PERF_EN to also exercise the activity counters.
module tb_data_memory;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  word_t       write_data;
  logic        mem_write;
  word_t       read_data;
`ifdef DMEM_PERF_EN
  logic [15:0] wr_count;
  logic [15:0] rd_addr_changes;
`endif

  int    testCount = 0;
  int    failCount = 0;
  word_t expQ[$];
  word_t expVal;

  data_memory dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .write_data     (write_data),
    .mem_write      (mem_write),
    .read_data      (read_data)
`ifdef DMEM_PERF_EN
    ,
    .wr_count       (wr_count),
    .rd_addr_changes(rd_addr_changes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic printMemory();
    for (int i = 0; i < DEPTH; i++) begin
      if (dut.mem[i] != '0) $display("mem[%0d] = %h", i, dut.mem[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; addr = 16'd3; write_data = '0; mem_write = 1'b0;
    expQ.push_back(16'h0000);
    #2;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL reset_initial: got %h expected %h", read_data, expVal);
    end
    reset = 1'b1; write_data = 16'hBEEF; mem_write = 1'b1;
    expQ.push_back(16'hBEEF);
    tick();
    mem_write = 1'b0; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL reset_prewrite: got %h expected %h", read_data, expVal);
    end
    reset = 1'b0;
    expQ.push_back(16'h0000);
    #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL reset_async_clear: got %h expected %h", read_data, expVal);
    end
    write_data = 16'h1111; mem_write = 1'b1;
    expQ.push_back(16'h0000);
    tick();
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL reset_write_blocked: got %h expected %h", read_data, expVal);
    end
    mem_write = 1'b0; #1; reset = 1'b1;
    expQ.push_back(16'h0000);
    #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL reset_after_release: got %h expected %h", read_data, expVal);
    end
  endtask

  task automatic test_write_read();
    addr = 16'd10; write_data = 16'h1234; mem_write = 1'b1;
    expQ.push_back(16'h0000);
    expQ.push_back(16'h1234);
    #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL write_old_value: got %h expected %h", read_data, expVal);
    end
    tick();
    mem_write = 1'b0; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL write_new_value: got %h expected %h", read_data, expVal);
    end
  endtask

  task automatic test_no_write();
    addr = 16'd10; write_data = 16'hFFFF; mem_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(16'h1234);
      tick();
      expVal = expQ.pop_front(); testCount++;
      if (read_data !== expVal) begin
        failCount++; $display("FAIL no_write edge %0d: got %h expected %h", i, read_data, expVal);
      end
    end
  endtask

  task automatic test_wrap();
    addr = 16'h0105; write_data = 16'hA5A5; mem_write = 1'b1;
    expQ.push_back(16'hA5A5);
    expQ.push_back(16'hA5A5);
    tick();
    mem_write = 1'b0; addr = 16'h0005; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL wrap_alias_low: got %h expected %h", read_data, expVal);
    end
    addr = 16'hFF05; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL wrap_alias_high: got %h expected %h", read_data, expVal);
    end
  endtask

  task automatic test_back_to_back();
    addr = 16'd8; write_data = 16'h5555; mem_write = 1'b1;
    tick();
    addr = 16'd7; write_data = 16'h0001;
    expQ.push_back(16'h0001);
    expQ.push_back(16'h0002);
    expQ.push_back(16'h5555);
    tick();
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL b2b_first: got %h expected %h", read_data, expVal);
    end
    write_data = 16'h0002;
    tick();
    mem_write = 1'b0; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL b2b_last_wins: got %h expected %h", read_data, expVal);
    end
    addr = 16'd8; #1;
    expVal = expQ.pop_front(); testCount++;
    if (read_data !== expVal) begin
      failCount++; $display("FAIL b2b_neighbour: got %h expected %h", read_data, expVal);
    end
  endtask

`ifdef DMEM_PERF_EN
  task automatic test_perf();
    logic [15:0] cntQ[$];
    logic [15:0] expCnt;
    reset = 1'b0; mem_write = 1'b0; addr = 16'd0; #1; reset = 1'b1; #1;
    write_data = 16'h0042; mem_write = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      addr = 16'(i);
      tick();
    end
    mem_write = 1'b0; #1;
    cntQ.push_back(16'd3); cntQ.push_back(16'd3);
    expCnt = cntQ.pop_front(); testCount++;
    if (wr_count !== expCnt) begin
      failCount++; $display("FAIL perf_wr_three: got %h expected %h", wr_count, expCnt);
    end
    expCnt = cntQ.pop_front(); testCount++;
    if (rd_addr_changes !== expCnt) begin
      failCount++; $display("FAIL perf_addr_three: got %h expected %h", rd_addr_changes, expCnt);
    end
    reset = 1'b0; addr = 16'd0; #1;
    cntQ.push_back(16'd0); cntQ.push_back(16'd0);
    expCnt = cntQ.pop_front(); testCount++;
    if (wr_count !== expCnt) begin
      failCount++; $display("FAIL perf_wr_clear: got %h expected %h", wr_count, expCnt);
    end
    expCnt = cntQ.pop_front(); testCount++;
    if (rd_addr_changes !== expCnt) begin
      failCount++; $display("FAIL perf_addr_clear: got %h expected %h", rd_addr_changes, expCnt);
    end
    reset = 1'b1; #1;
    mem_write = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      addr = 16'(i & 1);
      tick();
    end
    mem_write = 1'b0; #1;
    cntQ.push_back(16'hFFFF); cntQ.push_back(16'hFFFF);
    expCnt = cntQ.pop_front(); testCount++;
    if (wr_count !== expCnt) begin
      failCount++; $display("FAIL perf_wr_saturate: got %h expected %h", wr_count, expCnt);
    end
    expCnt = cntQ.pop_front(); testCount++;
    if (rd_addr_changes !== expCnt) begin
      failCount++; $display("FAIL perf_addr_saturate: got %h expected %h", rd_addr_changes, expCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_no_write();
    test_wrap();
    test_back_to_back();
    printMemory();
`ifdef DMEM_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
